// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: arbitrates redirects and stalls, and replays a
// redirect that arrives during an I-cache miss once the miss clears.
module fetch_sequencer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger,
  input  logic                     icache_miss,
  input  logic                     load_use_hazard,
  input  logic                     ex_branch_taken,
  input  logic [ADDRESS_WIDTH-1:0] ex_branch_target,
  input  logic                     trap_req,
  input  logic [ADDRESS_WIDTH-1:0] trap_vector,
  output logic                     pc_stall,
  output logic                     pc_branch,
  output logic [ADDRESS_WIDTH-1:0] pc_target,
  output logic                     stall_if_id,
  output logic                     flush_if_id,
  output logic                     flush_id_ex,
  output logic [COUNT_WIDTH-1:0]   stall_cycles
);

  typedef enum logic [1:0] {HALT, RUN, MISS, MISS_REDIR} state_t;

  state_t                   state, state_nxt;
  logic                     pending_valid, pending_valid_nxt;
  logic [ADDRESS_WIDTH-1:0] pending_target, pending_target_nxt;

  logic                     redir;
  logic [ADDRESS_WIDTH-1:0] redir_target;

  assign redir        = trap_req | ex_branch_taken;
  assign redir_target = trap_req ? trap_vector : ex_branch_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HALT;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      stall_cycles   <= '0;
    end else begin
      state          <= state_nxt;
      pending_valid  <= pending_valid_nxt;
      pending_target <= pending_target_nxt;
      if (state != HALT && trigger && pc_stall && stall_cycles != {COUNT_WIDTH{1'b1}})
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // RUN and MISS share transitions: a miss that clears behaves exactly like RUN.
  always_comb begin
    state_nxt          = state;
    pending_valid_nxt  = pending_valid;
    pending_target_nxt = pending_target;
    if (!trigger) begin
      state_nxt         = HALT;
      pending_valid_nxt = 1'b0;
    end else begin
      case (state)
        HALT: state_nxt = RUN;
        RUN, MISS: begin
          if (redir && icache_miss) begin
            state_nxt          = MISS_REDIR;
            pending_valid_nxt  = 1'b1;
            pending_target_nxt = redir_target;
          end else if (icache_miss) begin
            state_nxt = MISS;
          end else begin
            state_nxt = RUN;
          end
        end
        MISS_REDIR: begin
          if (icache_miss) begin
            if (trap_req) pending_target_nxt = trap_vector;
          end else begin
            state_nxt         = RUN;
            pending_valid_nxt = 1'b0;
          end
        end
        default: state_nxt = HALT;
      endcase
    end
  end

  always_comb begin
    pc_stall    = 1'b0;
    pc_branch   = 1'b0;
    pc_target   = '0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!trigger || state == HALT) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      case (state)
        RUN, MISS: begin
          if (redir && !icache_miss) begin
            pc_branch   = 1'b1;
            pc_target   = redir_target;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (redir) begin
            pc_stall    = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (icache_miss) begin
            pc_stall = 1'b1;
            // A fresh miss with a load-use hazard holds IF/ID rather than bubbling it.
            if (state == RUN && load_use_hazard) begin
              stall_if_id = 1'b1;
              flush_id_ex = 1'b1;
            end else begin
              flush_if_id = 1'b1;
            end
          end else if (load_use_hazard) begin
            pc_stall    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
        MISS_REDIR: begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (icache_miss) begin
            pc_stall = 1'b1;
          end else begin
            pc_branch = 1'b1;
            pc_target = trap_req ? trap_vector : pending_target;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
